// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache geometry, address view, frame record and FSM state.
// SETS is fixed here so the packed address view and frame widths follow from it.
package cpu_types_pkg;

  localparam int unsigned SETS  = 16;
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache; counter ports exist only
// when ICACHE_STATS_EN is defined. The cache uses the slave modport, its environment the master.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        inval;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  modport slave (
    input  imemREN, imemaddr, inval, iwait, iload,
    output ihit, imemload, iREN, iaddr
`ifdef ICACHE_STATS_EN
    , output hit_count, miss_count
`endif
  );

  modport master (
    output imemREN, imemaddr, inval, iwait, iload,
    input  ihit, imemload, iREN, iaddr
`ifdef ICACHE_STATS_EN
    , input hit_count, miss_count
`endif
  );
endinterface

// File: rtl/icache_frames.sv
// Frame store for the instruction cache: async read port, one write port, clear-all.
// Only the valid bits are reset; tag and data are qualified by valid.
module icache_frames
  import cpu_types_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] ridx_i,
  output icache_frame_t    rframe_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  icache_frame_t    wframe_i,
  input  logic             clr_i
);
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  // The write follows the clear so a fill landing with clr_i carries its own valid value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q <= '0;
      if (we_i)  valid_q[widx_i] <= wframe_i.valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[widx_i]  <= wframe_i.tag;
      data_q[widx_i] <= wframe_i.data;
    end
  end

  always_comb begin
    rframe_o.valid = valid_q[ridx_i];
    rframe_o.tag   = tag_q[ridx_i];
    rframe_o.data  = data_q[ridx_i];
  end
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame, single outstanding fill.
// Hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache
  import cpu_types_pkg::*;
(
  input logic     CLK,
  input logic     nRST,
  icache_if.slave cif
);
  icache_state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic          poison_q, poison_d;
  icachef_t      req, fill;
  icache_frame_t rframe, wframe;
  logic          tag_hit, hit, miss, fill_done;
  logic          unused_bytoff;

  assign req           = icachef_t'(cif.imemaddr);
  assign fill          = icachef_t'(miss_addr_q);
  assign unused_bytoff = ^{req.bytoff, fill.bytoff};

  assign tag_hit   = rframe.valid && (rframe.tag == req.tag);
  assign hit       = (state_q == IDLE) && cif.imemREN && tag_hit;
  assign miss      = (state_q == IDLE) && cif.imemREN && !tag_hit;
  assign fill_done = (state_q == FETCH) && !cif.iwait;

  // An invalidate seen during the fill, or on its last cycle, lands the frame invalid.
  always_comb begin
    wframe.valid = ~(poison_q | cif.inval);
    wframe.tag   = fill.tag;
    wframe.data  = cif.iload;
  end

  icache_frames u_frames (
    .clk_i    (CLK),
    .rst_ni   (nRST),
    .ridx_i   (req.idx),
    .rframe_o (rframe),
    .we_i     (fill_done),
    .widx_i   (fill.idx),
    .wframe_i (wframe),
    .clr_i    (cif.inval)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      poison_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      poison_q    <= poison_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    poison_d    = poison_q;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          state_d     = FETCH;
          miss_addr_d = {req.tag, req.idx, 2'b00};
        end
      end
      FETCH: begin
        if (!cif.iwait) begin
          state_d  = IDLE;
          poison_d = 1'b0;
        end else if (cif.inval) begin
          poison_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cif.ihit     = hit;
    cif.imemload = hit ? rframe.data : '0;
    cif.iREN     = (state_q == FETCH);
    cif.iaddr    = (state_q == FETCH) ? miss_addr_q : '0;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign cif.hit_count  = hit_cnt_q;
  assign cif.miss_count = miss_cnt_q;
`endif
endmodule
